idex_stage: RTL and testbench

ID/EX pipeline stage of the 5-stage RV32I core: registers decoded operands and control from ID and presents them to EX, to the operand forwarding logic (rs1/rs2 indices) and to EX/MEM. Integrates load-use hazard detection: inserts a single-cycle bubble and freezes IF/ID and PC while a dependent instruction waits. Also handles branch-flush and global-hold control, and keeps wrapping bubble/flush event counters for performance debug.

---
 rtl/core_pkg.sv | 41 ++++
 rtl/hazard_detect.sv | 26 ++
 rtl/idex_stage.sv | 179 +++++++++++++++++
 tb/tb_idex_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: ALU opcodes, ID/EX control bundle, datapath widths.
package core_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned ALU_OP_W  = 4;
   localparam int unsigned REG_IDX_W = 5;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_SLL  = 4'h2,
      ALU_SLT  = 4'h3,
      ALU_SLTU = 4'h4,
      ALU_XOR  = 4'h5,
      ALU_SRL  = 4'h6,
      ALU_SRA  = 4'h7,
      ALU_OR   = 4'h8,
      ALU_AND  = 4'h9,
      ALU_LUI  = 4'hA,
      ALU_NOP  = 4'hF
   } alu_op_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    write_enable;
   } idex_ctrl_t;

   localparam idex_ctrl_t CTRL_BUBBLE = '{
      alu_op:       ALU_NOP,
      alu_src:      1'b0,
      mem_read:     1'b0,
      mem_write:    1'b0,
      mem_to_reg:   1'b0,
      write_enable: 1'b0
   };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load sitting in EX and the instruction in ID.
module hazard_detect
   import core_pkg::*;
(
   input  logic                 ex_valid,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 id_valid,
   input  logic                 id_uses_rs1,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic                 id_uses_rs2,
   input  logic [REG_IDX_W-1:0] id_rs2,
   output logic                 load_use
);

   logic rs1_match;
   logic rs2_match;

   // x0 never carries a dependency, so a load into x0 cannot stall.
   always_comb begin
      rs1_match = id_uses_rs1 & (id_rs1 == ex_rd);
      rs2_match = id_uses_rs2 & (id_rs2 == ex_rd);
      load_use  = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid & (rs1_match | rs2_match);
   end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold control and
// wrapping bubble/flush event counters.
module idex_stage
   import core_pkg::*;
#(
   parameter int unsigned XLEN    = core_pkg::XLEN,
   parameter int unsigned ALUOP_W = core_pkg::ALU_OP_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [4:0]         in_rs1,
   input  logic [4:0]         in_rs2,
   input  logic [4:0]         in_rd,
   input  logic               in_uses_rs1,
   input  logic               in_uses_rs2,
   input  logic [XLEN-1:0]    in_rs1_data,
   input  logic [XLEN-1:0]    in_rs2_data,
   input  logic [XLEN-1:0]    in_imm,
   input  logic [ALUOP_W-1:0] in_alu_op,
   input  logic               in_alu_src,
   input  logic               in_mem_read,
   input  logic               in_mem_write,
   input  logic               in_mem_to_reg,
   input  logic               in_write_enable,
   input  logic               in_flush,
   input  logic               in_hold,
   output logic               out_valid,
   output logic [XLEN-1:0]    out_pc,
   output logic [XLEN-1:0]    out_rs1_data,
   output logic [XLEN-1:0]    out_rs2_data,
   output logic [XLEN-1:0]    out_imm,
   output logic [4:0]         out_rs1,
   output logic [4:0]         out_rs2,
   output logic [4:0]         out_rd,
   output logic [ALUOP_W-1:0] out_alu_op,
   output logic               out_alu_src,
   output logic               out_mem_read,
   output logic               out_mem_write,
   output logic               out_mem_to_reg,
   output logic               out_write_enable,
   output logic               out_stall_IFID,
   output logic [31:0]        out_bubble_count,
   output logic [31:0]        out_flush_count
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [4:0]      rs1_q, rs1_d;
   logic [4:0]      rs2_q, rs2_d;
   logic [4:0]      rd_q, rd_d;
   idex_ctrl_t      ctrl_q, ctrl_d;
   logic [31:0]     bubble_cnt_q, bubble_cnt_d;
   logic [31:0]     flush_cnt_q, flush_cnt_d;

   logic hazard;
   logic take;
   logic clear;

   hazard_detect u_hazard_detect (
      .ex_valid    (valid_q),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_rd       (rd_q),
      .id_valid    (in_valid),
      .id_uses_rs1 (in_uses_rs1),
      .id_rs1      (in_rs1),
      .id_uses_rs2 (in_uses_rs2),
      .id_rs2      (in_rs2),
      .load_use    (hazard)
   );

   // Hold already freezes IF/ID globally, and a flush kills the waiting instruction.
   assign out_stall_IFID = hazard & ~in_flush & ~in_hold;

   // An idle ID slot is loaded as a bubble so control never leaks with valid low.
   assign take  = ~in_hold & ~in_flush & ~hazard & in_valid;
   assign clear = ~in_hold & ~take;

   always_comb begin
      valid_d      = valid_q;
      pc_d         = pc_q;
      rs1_data_d   = rs1_data_q;
      rs2_data_d   = rs2_data_q;
      imm_d        = imm_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      rd_d         = rd_q;
      ctrl_d       = ctrl_q;
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;

      if (!in_hold) begin
         if (in_flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
         end else if (hazard) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
         end
      end

      if (take) begin
         valid_d    = 1'b1;
         pc_d       = in_pc;
         rs1_data_d = in_rs1_data;
         rs2_data_d = in_rs2_data;
         imm_d      = in_imm;
         rs1_d      = in_rs1;
         rs2_d      = in_rs2;
         rd_d       = in_rd;
         ctrl_d     = '{
            alu_op:       alu_op_e'(in_alu_op),
            alu_src:      in_alu_src,
            mem_read:     in_mem_read,
            mem_write:    in_mem_write,
            mem_to_reg:   in_mem_to_reg,
            write_enable: in_write_enable
         };
      end else if (clear) begin
         valid_d    = 1'b0;
         pc_d       = '0;
         rs1_data_d = '0;
         rs2_data_d = '0;
         imm_d      = '0;
         rs1_d      = '0;
         rs2_d      = '0;
         rd_d       = '0;
         ctrl_d     = CTRL_BUBBLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q      <= 1'b0;
         pc_q         <= '0;
         rs1_data_q   <= '0;
         rs2_data_q   <= '0;
         imm_q        <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         ctrl_q       <= CTRL_BUBBLE;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         valid_q      <= valid_d;
         pc_q         <= pc_d;
         rs1_data_q   <= rs1_data_d;
         rs2_data_q   <= rs2_data_d;
         imm_q        <= imm_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         ctrl_q       <= ctrl_d;
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign out_valid        = valid_q;
   assign out_pc           = pc_q;
   assign out_rs1_data     = rs1_data_q;
   assign out_rs2_data     = rs2_data_q;
   assign out_imm          = imm_q;
   assign out_rs1          = rs1_q;
   assign out_rs2          = rs2_q;
   assign out_rd           = rd_q;
   assign out_alu_op       = ctrl_q.alu_op;
   assign out_alu_src      = ctrl_q.alu_src;
   assign out_mem_read     = ctrl_q.mem_read;
   assign out_mem_write    = ctrl_q.mem_write;
   assign out_mem_to_reg   = ctrl_q.mem_to_reg;
   assign out_write_enable = ctrl_q.write_enable;
   assign out_bubble_count = bubble_cnt_q;
   assign out_flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Directed table-driven bench for idex_stage: normal flow, load-use, x0/unused sources,
// flush priority, hold freeze, counter wrap and asynchronous reset.
module tb_idex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_uses_rs1, in_uses_rs2;
   logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [3:0]  in_alu_op;
   logic        in_alu_src, in_mem_read, in_mem_write, in_mem_to_reg, in_write_enable;
   logic        in_flush, in_hold;
   logic        out_valid;
   logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [3:0]  out_alu_op;
   logic        out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg, out_write_enable;
   logic        out_stall_IFID;
   logic [31:0] out_bubble_count, out_flush_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   idex_stage dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_pc            (in_pc),
      .in_rs1           (in_rs1),
      .in_rs2           (in_rs2),
      .in_rd            (in_rd),
      .in_uses_rs1      (in_uses_rs1),
      .in_uses_rs2      (in_uses_rs2),
      .in_rs1_data      (in_rs1_data),
      .in_rs2_data      (in_rs2_data),
      .in_imm           (in_imm),
      .in_alu_op        (in_alu_op),
      .in_alu_src       (in_alu_src),
      .in_mem_read      (in_mem_read),
      .in_mem_write     (in_mem_write),
      .in_mem_to_reg    (in_mem_to_reg),
      .in_write_enable  (in_write_enable),
      .in_flush         (in_flush),
      .in_hold          (in_hold),
      .out_valid        (out_valid),
      .out_pc           (out_pc),
      .out_rs1_data     (out_rs1_data),
      .out_rs2_data     (out_rs2_data),
      .out_imm          (out_imm),
      .out_rs1          (out_rs1),
      .out_rs2          (out_rs2),
      .out_rd           (out_rd),
      .out_alu_op       (out_alu_op),
      .out_alu_src      (out_alu_src),
      .out_mem_read     (out_mem_read),
      .out_mem_write    (out_mem_write),
      .out_mem_to_reg   (out_mem_to_reg),
      .out_write_enable (out_write_enable),
      .out_stall_IFID   (out_stall_IFID),
      .out_bubble_count (out_bubble_count),
      .out_flush_count  (out_flush_count)
   );

   // misc = {alu_src, mem_to_reg, mem_write}; rs2_data = ~rs1_data, imm = rs1_data + 1
   typedef struct {
      logic        valid, flush, hold;
      logic [4:0]  rs1, rs2, rd;
      logic        u1, u2;
      logic [3:0]  op;
      logic        mr, we;
      logic [2:0]  misc;
      logic [31:0] d1, pc;
      logic        e_stall, e_valid;
      logic [4:0]  e_rd;
      logic [9:0]  e_rs12;
      logic [3:0]  e_op;
      logic        e_mr, e_we;
      logic [2:0]  e_misc;
      logic [31:0] e_d1, e_pc, e_bc, e_fc;
   } vec_t;

   function automatic vec_t vin(logic valid, logic flush, logic hold, logic [4:0] rs1,
                                logic [4:0] rs2, logic [4:0] rd, logic u1, logic u2,
                                logic [3:0] op, logic mr, logic we, logic [2:0] misc,
                                logic [31:0] d1, logic [31:0] pc);
      vec_t v;
      v.valid = valid; v.flush = flush; v.hold = hold;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2;
      v.op = op; v.mr = mr; v.we = we; v.misc = misc; v.d1 = d1; v.pc = pc;
      v.e_stall = 0; v.e_valid = 0; v.e_rd = 0; v.e_rs12 = 0; v.e_op = 4'hF;
      v.e_mr = 0; v.e_we = 0; v.e_misc = 0; v.e_d1 = 0; v.e_pc = 0; v.e_bc = 0; v.e_fc = 0;
      return v;
   endfunction

   function automatic vec_t vx(vec_t vi, logic stall, logic valid, logic [4:0] rd,
                               logic [9:0] rs12, logic [3:0] op, logic mr, logic we,
                               logic [2:0] misc, logic [31:0] d1, logic [31:0] pc,
                               logic [31:0] bc, logic [31:0] fc);
      vec_t v = vi;
      v.e_stall = stall; v.e_valid = valid; v.e_rd = rd; v.e_rs12 = rs12; v.e_op = op;
      v.e_mr = mr; v.e_we = we; v.e_misc = misc; v.e_d1 = d1; v.e_pc = pc;
      v.e_bc = bc; v.e_fc = fc;
      return v;
   endfunction

   // Expect the applied instruction to appear unchanged in EX.
   function automatic vec_t vl(vec_t v, logic [31:0] bc, logic [31:0] fc);
      return vx(v, 1'b0, 1'b1, v.rd, {v.rs1, v.rs2}, v.op, v.mr, v.we, v.misc, v.d1, v.pc,
                bc, fc);
   endfunction

   // Expect a bubble in EX.
   function automatic vec_t vb(vec_t v, logic stall, logic [31:0] bc, logic [31:0] fc);
      return vx(v, stall, 1'b0, 5'd0, 10'd0, 4'hF, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, bc, fc);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid = v.valid; in_flush = v.flush; in_hold = v.hold;
      in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
      in_uses_rs1 = v.u1; in_uses_rs2 = v.u2;
      in_alu_op = v.op; in_mem_read = v.mr; in_write_enable = v.we;
      {in_alu_src, in_mem_to_reg, in_mem_write} = v.misc;
      in_rs1_data = v.d1; in_rs2_data = ~v.d1; in_imm = v.d1 + 32'd1; in_pc = v.pc;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      @(negedge clk);
      drive(v);
      #1;
      chk({tag, ".stall"}, {31'd0, out_stall_IFID}, {31'd0, v.e_stall});
      @(posedge clk);
      #1;
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v.e_valid});
      chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, v.e_rd});
      chk({tag, ".rs12"}, {22'd0, out_rs1, out_rs2}, {22'd0, v.e_rs12});
      chk({tag, ".alu_op"}, {28'd0, out_alu_op}, {28'd0, v.e_op});
      chk({tag, ".mem_read"}, {31'd0, out_mem_read}, {31'd0, v.e_mr});
      chk({tag, ".we"}, {31'd0, out_write_enable}, {31'd0, v.e_we});
      chk({tag, ".misc"}, {29'd0, out_alu_src, out_mem_to_reg, out_mem_write},
          {29'd0, v.e_misc});
      chk({tag, ".rs1_data"}, out_rs1_data, v.e_d1);
      chk({tag, ".rs2_data"}, out_rs2_data, (v.e_d1 == 0) ? 32'd0 : ~v.e_d1);
      chk({tag, ".imm"}, out_imm, (v.e_d1 == 0) ? 32'd0 : v.e_d1 + 32'd1);
      chk({tag, ".pc"}, out_pc, v.e_pc);
      chk({tag, ".bubble_cnt"}, out_bubble_count, v.e_bc);
      chk({tag, ".flush_cnt"}, out_flush_count, v.e_fc);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, ".rd"}, {27'd0, out_rd}, 32'd0);
      chk({tag, ".we"}, {31'd0, out_write_enable}, 32'd0);
      chk({tag, ".mem_read"}, {31'd0, out_mem_read}, 32'd0);
      chk({tag, ".alu_op"}, {28'd0, out_alu_op}, 32'h0000000F);
      chk({tag, ".rs1_data"}, out_rs1_data, 32'd0);
      chk({tag, ".pc"}, out_pc, 32'd0);
      chk({tag, ".stall"}, {31'd0, out_stall_IFID}, 32'd0);
      chk({tag, ".bubble_cnt"}, out_bubble_count, 32'd0);
      chk({tag, ".flush_cnt"}, out_flush_count, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[14];
      vec_t v;

      // ADD=0 SUB=1 LUI=A; LW misc=110 (alu_src, mem_to_reg)
      tbl[0]  = vl(vin(1,0,0, 5'd1,5'd2,5'd3,  1,1, 4'h0,0,1,3'b000, 32'h11,32'h100), 0, 0);
      tbl[1]  = vl(vin(1,0,0, 5'd3,5'd0,5'd5,  1,0, 4'h0,1,1,3'b110, 32'h22,32'h104), 0, 0);
      tbl[2]  = vb(vin(1,0,0, 5'd5,5'd1,5'd6,  1,1, 4'h0,0,1,3'b000, 32'h33,32'h108), 1, 1, 0);
      tbl[3]  = vl(vin(1,0,0, 5'd5,5'd1,5'd6,  1,1, 4'h0,0,1,3'b000, 32'h33,32'h108), 1, 0);
      tbl[4]  = vl(vin(1,0,0, 5'd1,5'd0,5'd0,  1,0, 4'h0,1,1,3'b110, 32'h44,32'h10C), 1, 0);
      tbl[5]  = vl(vin(1,0,0, 5'd0,5'd2,5'd7,  1,1, 4'h1,0,1,3'b000, 32'h55,32'h110), 1, 0);
      tbl[6]  = vl(vin(1,0,0, 5'd2,5'd0,5'd5,  1,0, 4'h0,1,1,3'b110, 32'h66,32'h114), 1, 0);
      tbl[7]  = vl(vin(1,0,0, 5'd5,5'd5,5'd7,  0,0, 4'hA,0,1,3'b100, 32'h77,32'h118), 1, 0);
      tbl[8]  = vl(vin(1,0,0, 5'd2,5'd0,5'd5,  1,0, 4'h0,1,1,3'b110, 32'h88,32'h11C), 1, 0);
      tbl[9]  = vb(vin(1,1,0, 5'd1,5'd5,5'd9,  1,1, 4'h0,0,1,3'b000, 32'h99,32'h120), 0, 1, 1);
      tbl[10] = vb(vin(0,0,0, 5'd8,5'd9,5'd8,  1,1, 4'h2,1,1,3'b111, 32'hAA,32'h124), 0, 1, 1);
      tbl[11] = vl(vin(1,0,0, 5'd1,5'd0,5'd4,  1,0, 4'h0,1,1,3'b110, 32'hBB,32'h128), 1, 1);
      tbl[12] = vb(vin(1,0,0, 5'd1,5'd4,5'd10, 0,1, 4'h0,0,1,3'b000, 32'hCC,32'h12C), 1, 2, 1);
      tbl[13] = vl(vin(1,0,0, 5'd1,5'd4,5'd10, 0,1, 4'h0,0,1,3'b000, 32'hCC,32'h12C), 2, 1);

      reset = 1'b0;
      drive(vin(0,0,0, 5'd0,5'd0,5'd0, 0,0, 4'h0,0,0,3'b000, 32'd0,32'd0));
      repeat (2) @(posedge clk);
      #1;
      chk_reset("por");
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_vec(tbl[i], $sformatf("v%0d", i));
      end

      // Hold for three cycles with a dependent instruction waiting behind a load.
      run_vec(vl(vin(1,0,0, 5'd3,5'd0,5'd5, 1,0, 4'h0,1,1,3'b110, 32'hDD,32'h200), 2, 1),
              "h_lw");
      for (int k = 0; k < 3; k++) begin
         v = vin(1,0,1, 5'd5,5'd1,5'd6, 1,1, 4'h0,0,1,3'b000, 32'hE0 + k, 32'h204 + 4*k);
         run_vec(vx(v, 0, 1, 5'd5, {5'd3, 5'd0}, 4'h0, 1, 1, 3'b110, 32'hDD, 32'h200, 2, 1),
                 $sformatf("h_hold%0d", k));
      end
      run_vec(vb(vin(1,0,0, 5'd5,5'd1,5'd6, 1,1, 4'h0,0,1,3'b000, 32'hEE,32'h210), 1, 3, 1),
              "h_rel_bubble");
      run_vec(vl(vin(1,0,0, 5'd5,5'd1,5'd6, 1,1, 4'h0,0,1,3'b000, 32'hEE,32'h210), 3, 1),
              "h_rel_load");

      // Flush counter wrap from a forced all-ones value.
      force dut.flush_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.flush_cnt_q;
      run_vec(vb(vin(1,1,0, 5'd1,5'd2,5'd3, 1,1, 4'h0,0,1,3'b000, 32'h123,32'h300), 0, 3, 0),
              "wrap");

      // Asynchronous reset mid-stream, with hold asserted.
      run_vec(vl(vin(1,0,0, 5'd1,5'd2,5'd3, 1,1, 4'h8,0,1,3'b001, 32'h456,32'h304), 3, 0),
              "pre_rst");
      #2;
      in_hold = 1'b1;
      reset   = 1'b0;
      #1;
      chk_reset("mid_rst");
      @(negedge clk);
      reset = 1'b1;
      run_vec(vl(vin(1,0,0, 5'd2,5'd1,5'd4, 1,1, 4'h5,0,1,3'b000, 32'h789,32'h308), 0, 0),
              "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
